snd_trig_sched: RTL and testbench
=================================

Name: snd_trig_sched

Overview:
- Scheduler for one shared discrete-sound tone/noise gate: the jk74109 toggle flop plus a 4-bit decay envelope.
- Several sound-trigger requesters share this gate. The block latches requests, arbitrates by fixed priority, and sequences the flop's pre/clr/j/k controls.
- Each granted event runs a programmed hold time, then a linear decay. All sequencing runs at the 6 kHz enable rate inside the sound board clock domain.

Parameters:
- NREQ, 4, number of requesters; index 0 has highest priority.
- CW, 8, width of the per-requester hold-duration field, in 6 kHz ticks.
- DEC_DIV, 4, 6 kHz ticks per envelope decrement step (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_6KHz_en  in  1  single-cycle tick enable at 6 kHz
- req  in  NREQ  trigger requests, level; rising edge is captured
- dur  in  NREQ*CW  hold duration per requester; requester i uses bits [i*CW +: CW]
- grant  out  NREQ  one-hot owner of the gate; all zeros when idle
- busy  out  1  high in any state other than IDLE
- ff_pre  out  1  to jk74109 pre; active low
- ff_clr  out  1  to jk74109 clr; active low
- ff_j  out  1  to jk74109 j
- ff_k  out  1  to jk74109 k
- env  out  4  envelope level, 15 = full
- done  out  1  one-clk pulse when an event finishes or is preempted

Behaviour:
- Reset values:
  - state = IDLE; pending = 0; req_d = 0; grant = 0; busy = 0; env = 0; done = 0; counters = 0.
  - ff_pre = 1, ff_clr = 0, ff_j = 0, ff_k = 0. This holds the flop cleared (q = 0).
- Request capture, every clk, independent of the enable:
  - pending[i] is set when req[i] = 1 and req_d[i] = 0 (req_d is the previous-cycle req register).
  - pending[i] is cleared in the same cycle it is granted.
  - If a new edge and the grant for the same index fall in the same cycle, the set wins; pending stays 1.
- State transitions happen only on clk cycles with clk_6KHz_en = 1.
- IDLE:
  - Outputs: ff_clr = 0, ff_j = 0, ff_k = 0, env = 0.
  - If any pending bit is set: pick the lowest pending index w, set grant = onehot(w), clear pending[w], go to LOAD.
- LOAD (one tick):
  - hold_cnt <= dur[w]; env <= 15.
  - ff_clr = 1, ff_pre = 1, ff_j = 0, ff_k = 0 (flop released, holding).
  - If dur[w] = 0, go to DECAY; otherwise go to RUN.
- RUN:
  - ff_j = 1, ff_k = 0, so the flop toggles every tick; env = 15.
  - hold_cnt decrements each tick. When hold_cnt = 1 at a tick, go to DECAY on that tick.
  - RUN therefore lasts exactly dur[w] ticks.
- DECAY:
  - Flop keeps toggling (ff_j = 1, ff_k = 0).
  - div_cnt counts 0..DEC_DIV-1. On each wrap, env decrements by 1, saturating at 0.
  - When env = 0 on a wrap, go to IDLE: grant <= 0, ff_clr <= 0, done pulses for one clk.
  - DECAY lasts 15*DEC_DIV ticks.
- busy is high in LOAD, RUN and DECAY.
- grant is stable for the whole event.
- The dur input is sampled only in LOAD. Later changes to dur do not affect the running event.
- Back-to-back: if pending is nonzero at the IDLE-return tick, IDLE still lasts one tick (the flop is cleared for at least one tick) before the next LOAD.
- Requests arriving while busy stay pending and are served in priority order afterwards. Multiple edges on the same index collapse into one pending bit.
- ff_pre is never driven low by this block.
- reset asserted mid-event: immediately returns all outputs to their reset values, with no done pulse; pending is lost.

Optional Feature:
- Macro: SND_PREEMPT_EN.
- Defined:
  - In RUN or DECAY, a tick with a pending index p lower than the current owner w aborts the event.
  - On that tick: done pulses, ff_clr = 0 for that tick, grant <= onehot(p), pending[p] cleared, next state LOAD.
  - The preempted requester is not re-queued.
- Undefined: no preemption; the current event always runs to completion.

Test Plan:
- Reset, then tick with req = 0 -> grant = 0, busy = 0, ff_clr = 0, env = 0, no done.
- req[2] pulse, dur[2] = 3, DEC_DIV = 4 -> grant = 0100; RUN lasts 3 ticks with ff_j = 1, ff_k = 0, env = 15; decay 15->0 over 60 ticks; done pulses once; grant = 0.
- req[1] and req[3] rise in the same clk -> req[1] served first; req[3] starts after a 1-tick IDLE with ff_clr = 0.
- dur[0] = 0 -> LOAD goes directly to DECAY; no RUN ticks; env starts at 15.
- Macro defined: req[3] in RUN, then req[0] rises -> on the next tick done pulses and grant = 0001; req[3] is not re-served. Macro undefined: the req[3] event completes first, then req[0].
- reset asserted mid-DECAY with pending[1] set -> all outputs return to reset values at once; after release with no new req edge, the block stays IDLE.

Source files
------------

// File: rtl/snd_trig_sched.sv
// Fixed-priority scheduler for one shared tone/noise gate (jk74109 flop plus 4-bit decay envelope).
// Optional preemption by a higher-priority request is compiled in when SND_PREEMPT_EN is defined.
module snd_trig_sched #(
  parameter int NREQ    = 4,
  parameter int CW      = 8,
  parameter int DEC_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_6KHz_en,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] dur,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               ff_pre,
  output logic               ff_clr,
  output logic               ff_j,
  output logic               ff_k,
  output logic [3:0]         env,
  output logic               done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = (DEC_DIV > 1) ? $clog2(DEC_DIV) : 1;
  localparam logic [CW-1:0] HOLD_ONE = CW'(1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DEC_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DECAY = 2'd3
  } state_t;

  state_t            state_r;
  logic [NREQ-1:0]   pending_r;
  logic [NREQ-1:0]   req_d_r;
  logic [IW-1:0]     owner_r;
  logic [CW-1:0]     hold_cnt_r;
  logic [DW-1:0]     div_cnt_r;

  logic [NREQ-1:0]   rise_s;
  logic [NREQ-1:0]   take_mask_s;
  logic              pick_any_s;
  logic [IW-1:0]     pick_idx_s;
  logic              preempt_s;
  logic              take_s;
  logic [CW-1:0]     dur_sel_s;
  logic [3:0]        env_dec_s;

  function automatic logic [IW-1:0] lowest_idx(input logic [NREQ-1:0] v);
    lowest_idx = {IW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IW'(i);
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = {NREQ{1'b0}};
    onehot[idx] = 1'b1;
  endfunction

  // Edge detect, arbitration and preemption decision.
  always_comb begin
    rise_s     = req & ~req_d_r;
    pick_any_s = |pending_r;
    pick_idx_s = lowest_idx(pending_r);
    dur_sel_s  = dur[owner_r*CW +: CW];
    env_dec_s  = (env == 4'd0) ? 4'd0 : (env - 4'd1);
`ifdef SND_PREEMPT_EN
    preempt_s  = ((state_r == RUN) || (state_r == DECAY)) && pick_any_s && (pick_idx_s < owner_r);
`else
    preempt_s  = 1'b0;
`endif
    take_s      = clk_6KHz_en && (((state_r == IDLE) && pick_any_s) || preempt_s);
    take_mask_s = take_s ? onehot(pick_idx_s) : {NREQ{1'b0}};
  end

  // Request capture runs every clk; a fresh edge outranks the grant-clear of the same index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d_r   <= {NREQ{1'b0}};
      pending_r <= {NREQ{1'b0}};
    end else begin
      req_d_r   <= req;
      pending_r <= (pending_r & ~take_mask_s) | rise_s;
    end
  end

  // Event sequencer with registered flop controls, envelope and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= {IW{1'b0}};
      hold_cnt_r <= {CW{1'b0}};
      div_cnt_r  <= {DW{1'b0}};
      grant      <= {NREQ{1'b0}};
      busy       <= 1'b0;
      ff_pre     <= 1'b1;
      ff_clr     <= 1'b0;
      ff_j       <= 1'b0;
      ff_k       <= 1'b0;
      env        <= 4'd0;
      done       <= 1'b0;
    end else begin
      ff_pre <= 1'b1;
      ff_k   <= 1'b0;
      done   <= 1'b0;
      if (clk_6KHz_en) begin
        if (preempt_s) begin
          // Abort: flop held cleared for this tick, new owner reloads next tick.
          owner_r <= pick_idx_s;
          grant   <= onehot(pick_idx_s);
          ff_clr  <= 1'b0;
          ff_j    <= 1'b0;
          done    <= 1'b1;
          state_r <= LOAD;
        end else begin
          case (state_r)
            IDLE: begin
              env  <= 4'd0;
              ff_j <= 1'b0;
              if (pick_any_s) begin
                owner_r <= pick_idx_s;
                grant   <= onehot(pick_idx_s);
                busy    <= 1'b1;
                ff_clr  <= 1'b1;
                state_r <= LOAD;
              end else begin
                ff_clr  <= 1'b0;
                state_r <= IDLE;
              end
            end
            LOAD: begin
              hold_cnt_r <= dur_sel_s;
              div_cnt_r  <= {DW{1'b0}};
              env        <= 4'd15;
              ff_clr     <= 1'b1;
              ff_j       <= 1'b1;
              state_r    <= (dur_sel_s == {CW{1'b0}}) ? DECAY : RUN;
            end
            RUN: begin
              hold_cnt_r <= hold_cnt_r - HOLD_ONE;
              if (hold_cnt_r == HOLD_ONE) begin
                div_cnt_r <= {DW{1'b0}};
                state_r   <= DECAY;
              end else begin
                state_r   <= RUN;
              end
            end
            DECAY: begin
              if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DW{1'b0}};
                env       <= env_dec_s;
                if (env_dec_s == 4'd0) begin
                  grant   <= {NREQ{1'b0}};
                  busy    <= 1'b0;
                  ff_clr  <= 1'b0;
                  ff_j    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= IDLE;
                end else begin
                  state_r <= DECAY;
                end
              end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
              end
            end
            default: begin
              grant   <= {NREQ{1'b0}};
              busy    <= 1'b0;
              ff_clr  <= 1'b0;
              ff_j    <= 1'b0;
              env     <= 4'd0;
              state_r <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_snd_trig_sched.sv
// Directed bench for snd_trig_sched (NREQ=4, CW=8, DEC_DIV=4); one enabled tick every other clk.
module tb_snd_trig_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_6KHz_en = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [31:0] dur = 32'd0;
  logic [3:0]  grant;
  logic        busy, ff_pre, ff_clr, ff_j, ff_k, done;
  logic [3:0]  env;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int n;

  snd_trig_sched #(.NREQ(4), .CW(8), .DEC_DIV(4)) dut (
    .clk(clk), .reset(reset), .clk_6KHz_en(clk_6KHz_en), .req(req), .dur(dur),
    .grant(grant), .busy(busy), .ff_pre(ff_pre), .ff_clr(ff_clr), .ff_j(ff_j),
    .ff_k(ff_k), .env(env), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    clk_6KHz_en = 1'b1;
    @(negedge clk);
    clk_6KHz_en = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] mask);
    @(negedge clk);
    req = mask;
    @(negedge clk);
    req = 4'd0;
  endtask

  task automatic tick_until_done(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_pre", ff_pre, 1);
    check("rst_clr", ff_clr, 0);
    check("rst_jk", {ff_j, ff_k}, 0);
    check("rst_env", env, 0);
    check("rst_done", done, 0);
    reset = 1'b0;

    tick();
    check("idle_grant", grant, 0);
    check("idle_busy", busy, 0);
    check("idle_clr", ff_clr, 0);
    check("idle_done", done, 0);

    // Single event: requester 2, hold 3, decay 60 ticks
    dur[2*8 +: 8] = 8'd3;
    done_cnt = 0;
    pulse_req(4'b0100);
    tick();
    check("ev2_grant", grant, 4'b0100);
    check("ev2_busy", busy, 1);
    check("ev2_load_clr", ff_clr, 1);
    check("ev2_load_j", ff_j, 0);
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 1) begin
        dur[2*8 +: 8] = 8'd1;
        check("ev2_run_env", env, 15);
        check("ev2_run_jk", {ff_j, ff_k}, 2'b10);
      end
      if (k == 4) check("ev2_last_run_env", env, 15);
      if (k == 8) check("ev2_first_dec", env, 14);
      if (k == 63) begin
        check("ev2_env_1", env, 1);
        check("ev2_no_early_done", done_cnt, 0);
      end
      if (k == 64) begin
        check("ev2_done", done, 1);
        check("ev2_end_grant", grant, 0);
        check("ev2_end_busy", busy, 0);
        check("ev2_end_env", env, 0);
        check("ev2_end_clr", ff_clr, 0);
      end
    end
    tick();
    check("ev2_done_once", done_cnt, 1);
    check("ev2_stay_idle", grant, 0);

    // Simultaneous req[1] and req[3]: priority, then one-tick IDLE gap
    dur[1*8 +: 8] = 8'd2;
    dur[3*8 +: 8] = 8'd1;
    pulse_req(4'b1010);
    tick();
    check("pri_grant1", grant, 4'b0010);
    tick_until_done(n);
    check("pri_len1", n, 63);
    check("pri_gap_grant", grant, 0);
    check("pri_gap_clr", ff_clr, 0);
    tick();
    check("pri_grant3", grant, 4'b1000);
    check("pri_clr3", ff_clr, 1);
    tick_until_done(n);
    check("pri_len3", n, 62);

    // Zero hold: LOAD straight into DECAY
    dur[0 +: 8] = 8'd0;
    pulse_req(4'b0001);
    tick();
    check("z_grant", grant, 4'b0001);
    tick();
    check("z_env", env, 15);
    check("z_j", ff_j, 1);
    tick_until_done(n);
    check("z_len", n, 60);

    // Higher-priority request arriving during RUN of requester 3
    dur[3*8 +: 8] = 8'd10;
    pulse_req(4'b1000);
    tick();
    tick();
    tick();
    pulse_req(4'b0001);
    tick();
`ifdef SND_PREEMPT_EN
    check("pe_done", done, 1);
    check("pe_grant", grant, 4'b0001);
    check("pe_clr", ff_clr, 0);
    tick_until_done(n);
    check("pe_len0", n, 61);
    tick();
    check("pe_no_requeue", grant, 0);
    check("pe_no_requeue_busy", busy, 0);
`else
    check("np_no_done", done, 0);
    check("np_grant", grant, 4'b1000);
    tick_until_done(n);
    check("np_len3", n, 68);
    tick();
    check("np_grant0", grant, 4'b0001);
    tick_until_done(n);
    check("np_len0", n, 61);
`endif

    // Reset mid-DECAY with pending[1] set
    dur[2*8 +: 8] = 8'd3;
    pulse_req(4'b0100);
    tick();
    repeat (8) tick();
    pulse_req(4'b0010);
    done_cnt = 0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mr_grant", grant, 0);
    check("mr_busy", busy, 0);
    check("mr_pre", ff_pre, 1);
    check("mr_clr", ff_clr, 0);
    check("mr_jk", {ff_j, ff_k}, 0);
    check("mr_env", env, 0);
    check("mr_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check("mr_after_grant", grant, 0);
    check("mr_after_busy", busy, 0);
    check("mr_no_done", done_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
